// File: rtl/control_decode_stage.sv
// control_decode_stage
//   Decodes one RV32I(+M) instruction per cycle into a registered control word.
//   Legal DIV/DIVU/REM/REMU ops block the stage for MDIV_CYCLES cycles.
//
// Ports
//   CLK, RESET          clock (rising edge) and synchronous active-high reset
//   INSTRUCTION         instruction word from fetch
//   IN_VALID, IN_READY  input handshake; IN_READY is combinational
//   STALL               downstream busy: hold every registered output and the counter
//   FLUSH               discard held/in-flight work; wins over STALL and accept
//   OUT_VALID           registered control word valid
//   ALUOP .. ILLEGAL    registered control word fields
//   MDIV_BUSY           divide/remainder occupancy in progress
module control_decode_stage #(
    parameter int unsigned MDIV_CYCLES = 32,
    parameter bit          ENABLE_M    = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        IN_VALID,
    input  logic        STALL,
    input  logic        FLUSH,
    output logic        IN_READY,
    output logic        OUT_VALID,
    output logic [4:0]  ALUOP,
    output logic [2:0]  IMME_SELECT,
    output logic        MUX1_SELECT,
    output logic        MUX2_SELECT,
    output logic        BRANCH,
    output logic [2:0]  BR_SEL,
    output logic [1:0]  JUMP,
    output logic        WRITEENABLE,
    output logic [1:0]  MEM_WRITE,
    output logic [1:0]  MEM_READ,
    output logic        MEM_UNSIGNED,
    output logic        ILLEGAL,
    output logic        MDIV_BUSY
);

    localparam int unsigned CntW = (MDIV_CYCLES > 1) ? $clog2(MDIV_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(MDIV_CYCLES - 1);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [4:0] AluPass = 5'd0;
    localparam logic [4:0] AluAdd  = 5'd1;
    localparam logic [4:0] AluSub  = 5'd2;
    localparam logic [4:0] AluSll  = 5'd3;
    localparam logic [4:0] AluSlt  = 5'd4;
    localparam logic [4:0] AluSltu = 5'd5;
    localparam logic [4:0] AluXor  = 5'd6;
    localparam logic [4:0] AluSrl  = 5'd7;
    localparam logic [4:0] AluSra  = 5'd8;
    localparam logic [4:0] AluOr   = 5'd9;
    localparam logic [4:0] AluAnd  = 5'd10;
    localparam logic [4:0] AluMul  = 5'd11;

    localparam logic [2:0] ImmNone = 3'b000;
    localparam logic [2:0] ImmU    = 3'b001;
    localparam logic [2:0] ImmJ    = 3'b010;
    localparam logic [2:0] ImmI    = 3'b011;
    localparam logic [2:0] ImmB    = 3'b100;
    localparam logic [2:0] ImmS    = 3'b101;

    typedef enum logic [0:0] {StRun, StMdivWait} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       accept;
    logic       unused_operand_bits;

    logic [4:0] dec_aluop;
    logic [2:0] dec_imm;
    logic       dec_mux1;
    logic       dec_mux2;
    logic       dec_branch;
    logic [2:0] dec_br_sel;
    logic [1:0] dec_jump;
    logic       dec_we;
    logic [1:0] dec_mem_write;
    logic [1:0] dec_mem_read;
    logic       dec_mem_unsigned;
    logic       dec_illegal;
    logic       dec_is_div;

    assign opcode = INSTRUCTION[6:0];
    assign funct3 = INSTRUCTION[14:12];
    assign funct7 = INSTRUCTION[31:25];
    // Register indices and immediates are consumed by later stages.
    assign unused_operand_bits = ^{INSTRUCTION[24:15], INSTRUCTION[11:7]};

    assign IN_READY  = (state_q == StRun) && !STALL && !RESET;
    assign accept    = IN_VALID && IN_READY;
    assign MDIV_BUSY = (state_q == StMdivWait);

    always_comb begin
        dec_aluop        = AluPass;
        dec_imm          = ImmNone;
        dec_mux1         = 1'b0;
        dec_mux2         = 1'b0;
        dec_branch       = 1'b0;
        dec_br_sel       = 3'b000;
        dec_jump         = 2'b00;
        dec_we           = 1'b0;
        dec_mem_write    = 2'b00;
        dec_mem_read     = 2'b00;
        dec_mem_unsigned = 1'b0;
        dec_illegal      = (INSTRUCTION[1:0] != 2'b11);
        dec_is_div       = 1'b0;

        case (opcode)
            OpR: begin
                dec_we = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  dec_aluop = AluAdd;
                            3'b001:  dec_aluop = AluSll;
                            3'b010:  dec_aluop = AluSlt;
                            3'b011:  dec_aluop = AluSltu;
                            3'b100:  dec_aluop = AluXor;
                            3'b101:  dec_aluop = AluSrl;
                            3'b110:  dec_aluop = AluOr;
                            default: dec_aluop = AluAnd;
                        endcase
                    end
                    7'b0100000: begin
                        case (funct3)
                            3'b000:  dec_aluop = AluSub;
                            3'b101:  dec_aluop = AluSra;
                            default: dec_illegal = 1'b1;
                        endcase
                    end
                    7'b0000001: begin
                        if (ENABLE_M) begin
                            // M ops are numbered consecutively in funct3 order from MUL.
                            dec_aluop  = AluMul + {2'b00, funct3};
                            dec_is_div = funct3[2];
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OpImm: begin
                dec_imm  = ImmI;
                dec_mux2 = 1'b1;
                dec_we   = 1'b1;
                case (funct3)
                    3'b000: dec_aluop = AluAdd;
                    3'b010: dec_aluop = AluSlt;
                    3'b011: dec_aluop = AluSltu;
                    3'b100: dec_aluop = AluXor;
                    3'b110: dec_aluop = AluOr;
                    3'b111: dec_aluop = AluAnd;
                    3'b001: begin
                        if (funct7 == 7'b0000000) dec_aluop = AluSll;
                        else                      dec_illegal = 1'b1;
                    end
                    default: begin
                        if (funct7 == 7'b0000000)      dec_aluop = AluSrl;
                        else if (funct7 == 7'b0100000) dec_aluop = AluSra;
                        else                           dec_illegal = 1'b1;
                    end
                endcase
            end
            OpLoad: begin
                dec_aluop        = AluAdd;
                dec_imm          = ImmI;
                dec_mux2         = 1'b1;
                dec_we           = 1'b1;
                dec_mem_read     = funct3[1:0] + 2'd1;
                dec_mem_unsigned = funct3[2];
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    dec_illegal = 1'b1;
                end
            end
            OpStore: begin
                dec_aluop     = AluAdd;
                dec_imm       = ImmS;
                dec_mux2      = 1'b1;
                dec_mem_write = funct3[1:0] + 2'd1;
                if (funct3 >= 3'b011) dec_illegal = 1'b1;
            end
            OpBranch: begin
                dec_aluop  = AluSub;
                dec_imm    = ImmB;
                dec_branch = 1'b1;
                dec_br_sel = funct3;
                if (funct3[2:1] == 2'b01) dec_illegal = 1'b1;
            end
            OpJal: begin
                dec_aluop = AluAdd;
                dec_imm   = ImmJ;
                dec_mux1  = 1'b1;
                dec_mux2  = 1'b1;
                dec_jump  = 2'b01;
                dec_we    = 1'b1;
            end
            OpJalr: begin
                dec_aluop = AluAdd;
                dec_imm   = ImmI;
                dec_mux2  = 1'b1;
                dec_jump  = 2'b10;
                dec_we    = 1'b1;
            end
            OpLui: begin
                dec_aluop = AluPass;
                dec_imm   = ImmU;
                dec_mux2  = 1'b1;
                dec_we    = 1'b1;
            end
            OpAuipc: begin
                dec_aluop = AluAdd;
                dec_imm   = ImmU;
                dec_mux1  = 1'b1;
                dec_mux2  = 1'b1;
                dec_we    = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase

        // An illegal instruction carries no side effects: the whole word is
        // cleared so nothing partially decoded leaks downstream.
        if (dec_illegal) begin
            dec_aluop        = AluPass;
            dec_imm          = ImmNone;
            dec_mux1         = 1'b0;
            dec_mux2         = 1'b0;
            dec_branch       = 1'b0;
            dec_br_sel       = 3'b000;
            dec_jump         = 2'b00;
            dec_we           = 1'b0;
            dec_mem_write    = 2'b00;
            dec_mem_read     = 2'b00;
            dec_mem_unsigned = 1'b0;
            dec_is_div       = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= StRun;
            cnt_q        <= '0;
            OUT_VALID    <= 1'b0;
            ALUOP        <= '0;
            IMME_SELECT  <= '0;
            MUX1_SELECT  <= 1'b0;
            MUX2_SELECT  <= 1'b0;
            BRANCH       <= 1'b0;
            BR_SEL       <= '0;
            JUMP         <= '0;
            WRITEENABLE  <= 1'b0;
            MEM_WRITE    <= '0;
            MEM_READ     <= '0;
            MEM_UNSIGNED <= 1'b0;
            ILLEGAL      <= 1'b0;
        end else if (FLUSH) begin
            state_q     <= StRun;
            cnt_q       <= '0;
            OUT_VALID   <= 1'b0;
            BRANCH      <= 1'b0;
            JUMP        <= '0;
            WRITEENABLE <= 1'b0;
            MEM_WRITE   <= '0;
            MEM_READ    <= '0;
        end else if (!STALL) begin
            if (accept) begin
                OUT_VALID    <= 1'b1;
                ALUOP        <= dec_aluop;
                IMME_SELECT  <= dec_imm;
                MUX1_SELECT  <= dec_mux1;
                MUX2_SELECT  <= dec_mux2;
                BRANCH       <= dec_branch;
                BR_SEL       <= dec_br_sel;
                JUMP         <= dec_jump;
                WRITEENABLE  <= dec_we;
                MEM_WRITE    <= dec_mem_write;
                MEM_READ     <= dec_mem_read;
                MEM_UNSIGNED <= dec_mem_unsigned;
                ILLEGAL      <= dec_illegal;
                if (dec_is_div) begin
                    state_q <= StMdivWait;
                    cnt_q   <= CntLoad;
                end
            end else begin
                // Bubble: drop valid and every side-effecting enable.
                OUT_VALID   <= 1'b0;
                BRANCH      <= 1'b0;
                JUMP        <= '0;
                WRITEENABLE <= 1'b0;
                MEM_WRITE   <= '0;
                MEM_READ    <= '0;
                if (state_q == StMdivWait) begin
                    if (cnt_q <= CntW'(1)) begin
                        state_q <= StRun;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_control_decode_stage.sv
// Scoreboard bench for control_decode_stage. Instance a has the M extension,
// instance b has it disabled; both use MDIV_CYCLES=4 and share clock/reset/stall/flush.
module tb_control_decode_stage;

    typedef struct packed {
        logic [4:0] aluop;
        logic [2:0] imm;
        logic       mux1;
        logic       mux2;
        logic       branch;
        logic [2:0] br_sel;
        logic [1:0] jump;
        logic       we;
        logic [1:0] mem_write;
        logic [1:0] mem_read;
        logic       mem_unsigned;
        logic       illegal;
    } ctrl_t;

    logic CLK = 1'b0;
    logic RESET, STALL, FLUSH;

    logic [31:0] INSTRUCTION_a, INSTRUCTION_b;
    logic        IN_VALID_a, IN_VALID_b;
    logic        IN_READY_a, IN_READY_b, OUT_VALID_a, OUT_VALID_b;
    logic [4:0]  ALUOP_a, ALUOP_b;
    logic [2:0]  IMME_a, IMME_b, BR_SEL_a, BR_SEL_b;
    logic        MUX1_a, MUX1_b, MUX2_a, MUX2_b, BRANCH_a, BRANCH_b;
    logic [1:0]  JUMP_a, JUMP_b, MW_a, MW_b, MR_a, MR_b;
    logic        WE_a, WE_b, MU_a, MU_b, ILL_a, ILL_b, BUSY_a, BUSY_b;

    ctrl_t out_a, out_b;
    ctrl_t q_a[$];
    ctrl_t q_b[$];
    int    checks = 0;
    int    failures = 0;

    always #5 CLK = ~CLK;

    control_decode_stage #(.MDIV_CYCLES(4), .ENABLE_M(1'b1)) dut_a (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION_a), .IN_VALID(IN_VALID_a),
        .STALL(STALL), .FLUSH(FLUSH), .IN_READY(IN_READY_a), .OUT_VALID(OUT_VALID_a),
        .ALUOP(ALUOP_a), .IMME_SELECT(IMME_a), .MUX1_SELECT(MUX1_a), .MUX2_SELECT(MUX2_a),
        .BRANCH(BRANCH_a), .BR_SEL(BR_SEL_a), .JUMP(JUMP_a), .WRITEENABLE(WE_a),
        .MEM_WRITE(MW_a), .MEM_READ(MR_a), .MEM_UNSIGNED(MU_a), .ILLEGAL(ILL_a),
        .MDIV_BUSY(BUSY_a)
    );

    control_decode_stage #(.MDIV_CYCLES(4), .ENABLE_M(1'b0)) dut_b (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION_b), .IN_VALID(IN_VALID_b),
        .STALL(STALL), .FLUSH(FLUSH), .IN_READY(IN_READY_b), .OUT_VALID(OUT_VALID_b),
        .ALUOP(ALUOP_b), .IMME_SELECT(IMME_b), .MUX1_SELECT(MUX1_b), .MUX2_SELECT(MUX2_b),
        .BRANCH(BRANCH_b), .BR_SEL(BR_SEL_b), .JUMP(JUMP_b), .WRITEENABLE(WE_b),
        .MEM_WRITE(MW_b), .MEM_READ(MR_b), .MEM_UNSIGNED(MU_b), .ILLEGAL(ILL_b),
        .MDIV_BUSY(BUSY_b)
    );

    assign out_a = {ALUOP_a, IMME_a, MUX1_a, MUX2_a, BRANCH_a, BR_SEL_a, JUMP_a, WE_a,
                    MW_a, MR_a, MU_a, ILL_a};
    assign out_b = {ALUOP_b, IMME_b, MUX1_b, MUX2_b, BRANCH_b, BR_SEL_b, JUMP_b, WE_b,
                    MW_b, MR_b, MU_b, ILL_b};

    function automatic ctrl_t mk(input logic [4:0] alu, input logic [2:0] imm,
                                 input logic m1, input logic m2, input logic br,
                                 input logic [2:0] bs, input logic [1:0] j, input logic we,
                                 input logic [1:0] mw, input logic [1:0] mr,
                                 input logic mu, input logic ill);
        return {alu, imm, m1, m2, br, bs, j, we, mw, mr, mu, ill};
    endfunction

    function automatic ctrl_t ill_word();
        return mk(5'd0, 3'd0, 0, 0, 0, 3'd0, 2'd0, 0, 2'd0, 2'd0, 0, 1);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitors: a word is new when the last edge was not a hold; held words
    // are compared against the previously popped expectation.
    ctrl_t last_a, last_b;
    logic  held_a, held_b;

    always begin
        @(posedge CLK);
        held_a = STALL && !FLUSH && !RESET;
        @(negedge CLK);
        if (OUT_VALID_a === 1'b1) begin
            if (held_a) begin
                check("a_held_word", 32'(out_a), 32'(last_a));
            end else if (q_a.size() == 0) begin
                check("a_unexpected_valid", 32'(OUT_VALID_a), 32'd0);
            end else begin
                last_a = q_a.pop_front();
                check("a_ctrl_word", 32'(out_a), 32'(last_a));
            end
        end
    end

    always begin
        @(posedge CLK);
        held_b = STALL && !FLUSH && !RESET;
        @(negedge CLK);
        if (OUT_VALID_b === 1'b1) begin
            if (held_b) begin
                check("b_held_word", 32'(out_b), 32'(last_b));
            end else if (q_b.size() == 0) begin
                check("b_unexpected_valid", 32'(OUT_VALID_b), 32'd0);
            end else begin
                last_b = q_b.pop_front();
                check("b_ctrl_word", 32'(out_b), 32'(last_b));
            end
        end
    end

    // Waits (bounded) for IN_READY, presents one instruction for one edge.
    task automatic send(input bit to_b, input logic [31:0] ins, input ctrl_t e);
        int n = 0;
        while (!(to_b ? IN_READY_b : IN_READY_a) && n < 50) begin
            @(posedge CLK);
            #2;
            n++;
        end
        if (!(to_b ? IN_READY_b : IN_READY_a)) begin
            checks++;
            failures++;
            $display("FAIL send_ready_timeout: got=IN_READY low expected=IN_READY high");
            return;
        end
        if (to_b) begin
            INSTRUCTION_b = ins;
            IN_VALID_b = 1'b1;
            q_b.push_back(e);
        end else begin
            INSTRUCTION_a = ins;
            IN_VALID_a = 1'b1;
            q_a.push_back(e);
        end
        @(posedge CLK);
        #2;
        IN_VALID_a = 1'b0;
        IN_VALID_b = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_t e_add, e_div;
        e_add = mk(5'd1, 3'd0, 0, 0, 0, 3'd0, 2'd0, 1, 2'd0, 2'd0, 0, 0);
        e_div = mk(5'd15, 3'd0, 0, 0, 0, 3'd0, 2'd0, 1, 2'd0, 2'd0, 0, 0);
        RESET = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
        IN_VALID_a = 1'b0; IN_VALID_b = 1'b0;
        INSTRUCTION_a = 32'h0; INSTRUCTION_b = 32'h0;

        // Reset state
        repeat (2) step();
        check("reset_in_ready", 32'(IN_READY_a), 32'd0);
        check("reset_out_valid", 32'(OUT_VALID_a), 32'd0);
        check("reset_busy", 32'(BUSY_a), 32'd0);
        check("reset_ctrl_word", 32'(out_a), 32'd0);
        RESET = 1'b0;
        #1;
        check("ready_after_reset", 32'(IN_READY_a), 32'd1);

        // ADD then bubble
        send(0, 32'h002081B3, e_add);
        check("add_no_busy", 32'(BUSY_a), 32'd0);
        step();
        check("bubble_valid", 32'(OUT_VALID_a), 32'd0);
        check("bubble_we", 32'(WE_a), 32'd0);

        // Back-to-back directed decode vectors
        send(0, 32'h402081B3, mk(5'd2, 3'd0, 0, 0, 0, 3'd0, 2'd0, 1, 2'd0, 2'd0, 0, 0));
        send(0, 32'h4040D193, mk(5'd8, 3'd3, 0, 1, 0, 3'd0, 2'd0, 1, 2'd0, 2'd0, 0, 0));
        send(0, 32'h00812183, mk(5'd1, 3'd3, 0, 1, 0, 3'd0, 2'd0, 1, 2'd0, 2'd3, 0, 0));
        send(0, 32'h00814183, mk(5'd1, 3'd3, 0, 1, 0, 3'd0, 2'd0, 1, 2'd0, 2'd1, 1, 0));
        send(0, 32'h00212423, mk(5'd1, 3'd5, 0, 1, 0, 3'd0, 2'd0, 0, 2'd3, 2'd0, 0, 0));
        send(0, 32'h00211423, mk(5'd1, 3'd5, 0, 1, 0, 3'd0, 2'd0, 0, 2'd2, 2'd0, 0, 0));
        send(0, 32'h00209463, mk(5'd2, 3'd4, 0, 0, 1, 3'd1, 2'd0, 0, 2'd0, 2'd0, 0, 0));
        send(0, 32'h008000EF, mk(5'd1, 3'd2, 1, 1, 0, 3'd0, 2'd1, 1, 2'd0, 2'd0, 0, 0));
        send(0, 32'h000100E7, mk(5'd1, 3'd3, 0, 1, 0, 3'd0, 2'd2, 1, 2'd0, 2'd0, 0, 0));
        send(0, 32'h123451B7, mk(5'd0, 3'd1, 0, 1, 0, 3'd0, 2'd0, 1, 2'd0, 2'd0, 0, 0));
        send(0, 32'h12345197, mk(5'd1, 3'd1, 1, 1, 0, 3'd0, 2'd0, 1, 2'd0, 2'd0, 0, 0));
        send(0, 32'h0220B1B3, mk(5'd14, 3'd0, 0, 0, 0, 3'd0, 2'd0, 1, 2'd0, 2'd0, 0, 0));
        send(0, 32'hFFFFFFFF, ill_word());
        send(0, 32'h40409193, ill_word());  // SLLI with funct7 0100000
        send(0, 32'h00813183, ill_word());  // load funct3 011
        send(0, 32'h00213423, ill_word());  // store funct3 011
        send(0, 32'h0020A463, ill_word());  // branch funct3 010
        send(0, 32'h002081B0, ill_word());  // low bits != 11
        send(0, 32'h802081B3, ill_word());  // R-type funct7 1000000

        // MUL stays in RUN
        send(0, 32'h022081B3, mk(5'd11, 3'd0, 0, 0, 0, 3'd0, 2'd0, 1, 2'd0, 2'd0, 0, 0));
        check("mul_no_busy", 32'(BUSY_a), 32'd0);
        check("mul_ready", 32'(IN_READY_a), 32'd1);

        // DIV occupies the stage for 4 cycles in total
        send(0, 32'h0220C1B3, e_div);
        for (int i = 0; i < 3; i++) begin
            check("div_busy", 32'(BUSY_a), 32'd1);
            check("div_not_ready", 32'(IN_READY_a), 32'd0);
            if (i == 1) check("div_valid_dropped", 32'(OUT_VALID_a), 32'd0);
            step();
        end
        check("div_done_busy", 32'(BUSY_a), 32'd0);
        check("div_done_ready", 32'(IN_READY_a), 32'd1);

        // BEQ held through a 2-cycle stall
        send(0, 32'h00208463, mk(5'd2, 3'd4, 0, 0, 1, 3'd0, 2'd0, 0, 2'd0, 2'd0, 0, 0));
        STALL = 1'b1;
        #1;
        check("stall_not_ready", 32'(IN_READY_a), 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        STALL = 1'b0;
        step();
        check("after_stall_bubble", 32'(OUT_VALID_a), 32'd0);

        // REMU with a stall during the wait: counter must freeze
        send(0, 32'h0220F1B3, mk(5'd18, 3'd0, 0, 0, 0, 3'd0, 2'd0, 1, 2'd0, 2'd0, 0, 0));
        STALL = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        STALL = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("remu_stalled_busy", 32'(BUSY_a), 32'd1);
            step();
        end
        check("remu_done_busy", 32'(BUSY_a), 32'd0);

        // FLUSH one cycle after DIV aborts the wait
        send(0, 32'h0220C1B3, e_div);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        check("flush_busy", 32'(BUSY_a), 32'd0);
        check("flush_ready", 32'(IN_READY_a), 32'd1);
        check("flush_valid", 32'(OUT_VALID_a), 32'd0);

        // FLUSH beats STALL on a held word
        send(0, 32'h002081B3, e_add);
        STALL = 1'b1;
        FLUSH = 1'b1;
        step();
        STALL = 1'b0;
        FLUSH = 1'b0;
        check("flush_over_stall_valid", 32'(OUT_VALID_a), 32'd0);
        check("flush_over_stall_we", 32'(WE_a), 32'd0);

        // FLUSH beats accept
        INSTRUCTION_a = 32'h002081B3;
        IN_VALID_a = 1'b1;
        FLUSH = 1'b1;
        step();
        IN_VALID_a = 1'b0;
        FLUSH = 1'b0;
        check("flush_over_accept", 32'(OUT_VALID_a), 32'd0);

        // RESET in the middle of a divide wait
        send(0, 32'h0220C1B3, e_div);
        step();
        RESET = 1'b1;
        #1;
        check("reset_drops_ready", 32'(IN_READY_a), 32'd0);
        step();
        check("reset_mid_wait_busy", 32'(BUSY_a), 32'd0);
        check("reset_mid_wait_word", 32'(out_a), 32'd0);
        check("reset_mid_wait_valid", 32'(OUT_VALID_a), 32'd0);
        RESET = 1'b0;
        #1;
        check("ready_after_mid_reset", 32'(IN_READY_a), 32'd1);

        // Instance without the M extension
        send(1, 32'h022081B3, ill_word());
        send(1, 32'h0220C1B3, ill_word());
        check("b_div_no_busy", 32'(BUSY_b), 32'd0);
        check("b_div_ready", 32'(IN_READY_b), 32'd1);
        send(1, 32'h002081B3, e_add);

        repeat (3) step();
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
